// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   PC_W / INSTR_W : address and instruction word widths
//   ENTRY_W        : packed queue entry {pc, instr, abort}
//   *_OFS          : bit offsets of each field inside an entry
//   word_align()   : clears the byte-offset bits of an address
package instr_prefetch_queue_pkg;
    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int ENTRY_W   = PC_W + INSTR_W + 1;
    localparam int ABORT_OFS = 0;
    localparam int INSTR_OFS = 1;
    localparam int PC_OFS    = INSTR_W + 1;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// pq_fifo: generic synchronous FIFO with combinational head read.
//   i_clk / i_reset : clock, asynchronous active-high reset
//   i_push / i_pop  : write at wr ptr / advance rd ptr (both allowed when full)
//   i_flush         : empties the FIFO; dominates push and pop
//   i_wdata         : write data
//   o_rdata         : entry at rd ptr (caller qualifies with o_count != 0)
//   o_count         : occupied entries, 0..DEPTH
module pq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (i_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_rdata = mem[rd_ptr];
    assign o_count = count;
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: instruction fetch front end.
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   o_address1              : fetch address (fpc) to memory instruction port
//   i_data1/i_hit1/i_abort1 : same-cycle memory response for o_address1
//   i_flush, i_flush_pc     : redirect; empties queue and restarts fetch
//   o_valid/o_instr/o_pc/o_abort : head entry, all zero when empty
//   i_ready                 : decode accepts head
//   o_count                 : occupied entries
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    output logic [PC_W-1:0]        o_address1,
    input  logic [INSTR_W-1:0]     i_data1,
    input  logic                   i_hit1,
    input  logic                   i_abort1,
    input  logic                   i_flush,
    input  logic [PC_W-1:0]        i_flush_pc,
    output logic                   o_valid,
    output logic [INSTR_W-1:0]     o_instr,
    output logic [PC_W-1:0]        o_pc,
    output logic                   o_abort,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]    fpc;
    logic               halted;
    logic               push;
    logic               pop;
    logic               full;
    logic [ENTRY_W-1:0] head;
    logic [CW-1:0]      count;

    assign full    = (count == CW'(DEPTH));
    assign o_valid = (count != '0);
    // Flush beats both sides; a full queue may still accept when it pops.
    assign pop     = o_valid & i_ready & ~i_flush;
    assign push    = i_hit1 & ~halted & ~i_flush & (~full | pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fpc    <= RESET_PC;
            halted <= 1'b0;
        end else if (i_flush) begin
            fpc    <= word_align(i_flush_pc);
            halted <= 1'b0;
        end else if (push) begin
            fpc <= fpc + 32'd4;
            // An aborted fetch is delivered, then fetch stalls until redirected.
            if (i_abort1)
                halted <= 1'b1;
        end
    end

    pq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_flush),
        .i_wdata ({fpc, i_data1, i_abort1}),
        .o_rdata (head),
        .o_count (count)
    );

    assign o_address1 = fpc;
    assign o_count    = count;
    assign o_instr    = o_valid ? head[INSTR_OFS +: INSTR_W] : '0;
    assign o_pc       = o_valid ? head[PC_OFS +: PC_W]       : '0;
    assign o_abort    = o_valid & head[ABORT_OFS];
endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0) and its memory model controls
    logic [31:0] addr1, data1, flush_pc, o_instr, o_pc;
    logic        hit1, abort1, flush, ready, o_valid, o_abort;
    logic [2:0]  o_count;
    logic        hit_en = 1'b1, abort_en = 1'b0;
    logic [31:0] stop_addr = 32'h1, abort_addr = 32'h0;

    // second DUT for reset-PC wrap
    logic [31:0] addr_h, data_h, instr_h, pc_h;
    logic        valid_h, abort_h;
    logic [2:0]  count_h;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign data1  = mem_word(addr1);
    assign hit1   = hit_en && (addr1 != stop_addr);
    assign abort1 = abort_en && (addr1 == abort_addr);
    assign data_h = mem_word(addr_h);

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .i_clk(clk), .i_reset(rst), .o_address1(addr1), .i_data1(data1),
        .i_hit1(hit1), .i_abort1(abort1), .i_flush(flush), .i_flush_pc(flush_pc),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_abort(o_abort),
        .i_ready(ready), .o_count(o_count)
    );

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .i_clk(clk), .i_reset(rst), .o_address1(addr_h), .i_data1(data_h),
        .i_hit1(1'b1), .i_abort1(1'b0), .i_flush(1'b0), .i_flush_pc(32'h0),
        .o_valid(valid_h), .o_instr(instr_h), .o_pc(pc_h), .o_abort(abort_h),
        .i_ready(1'b1), .o_count(count_h)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        abort;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic [31:0] pc, input logic ab);
        exp_q.push_back('{pc, mem_word(pc), ab});
    endtask

    // monitor: compares every accepted head, and zeroed outputs when empty
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (o_valid && ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h, expected no entry", o_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", o_pc, e.pc);
                    chk("pop_instr", o_instr, e.instr);
                    chk("pop_abort", {31'b0, o_abort}, {31'b0, e.abort});
                end
            end else if (!o_valid) begin
                chk("empty_zero", o_instr | o_pc | {31'b0, o_abort}, 32'h0);
            end
        end
    end

    // asserts reset mid-cycle and checks outputs clear with no clock edge
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_count", {29'b0, o_count}, 32'h0);
        chk("rst_addr", addr1, 32'h0);
        chk("rst_hi_valid", {31'b0, valid_h}, 32'h0);
        chk("rst_hi_addr", addr_h, 32'hFFFF_FFF8);
        exp_q.delete();
        hit_en = 1'b1; abort_en = 1'b0; stop_addr = 32'h1;
        flush = 1'b0; flush_pc = 32'h0; ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'h0);
    endtask

    logic [31:0] hi_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        flush = 1'b0; flush_pc = 32'h0; ready = 1'b1;

        // 1: streaming from reset, plus reset-PC wrap on the second instance
        do_reset();
        stop_addr = 32'h20;
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4), 1'b0);
        release_rst();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_valid", {31'b0, o_valid}, 32'h1);
            chk("t1_pc", o_pc, 32'(i * 4));
            if (i < 3) chk("t6_hi_pc", pc_h, hi_exp[i]);
        end
        wait_drain("t1_drain");
        @(negedge clk);
        chk("t1_addr_stop", addr1, 32'h20);

        // 2: backpressure saturates queue, then drains in order
        do_reset();
        ready = 1'b0;
        release_rst();
        repeat (10) @(posedge clk);
        #1;
        chk("t2_count_full", {29'b0, o_count}, 32'h4);
        chk("t2_addr_hold", addr1, 32'h10);
        for (int i = 0; i < 5; i++) push_exp(32'(i * 4), 1'b0);
        stop_addr = 32'h14;
        ready = 1'b1;
        wait_drain("t2_drain");
        @(negedge clk);
        chk("t2_count_end", {29'b0, o_count}, 32'h0);

        // 3: abort halts fetch, flush restarts it
        do_reset();
        abort_en = 1'b1; abort_addr = 32'h8;
        push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b0); push_exp(32'h8, 1'b1);
        release_rst();
        repeat (6) @(posedge clk);
        #1;
        chk("t3_addr_halt", addr1, 32'hC);
        chk("t3_count_halt", {29'b0, o_count}, 32'h0);
        flush = 1'b1; flush_pc = 32'h40; abort_en = 1'b0; stop_addr = 32'h48;
        push_exp(32'h40, 1'b0); push_exp(32'h44, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("t3_addr_flush", addr1, 32'h40);
        wait_drain("t3_drain");

        // 4: flush while full and popping, unaligned target
        do_reset();
        ready = 1'b0;
        release_rst();
        repeat (6) @(posedge clk);
        #1;
        chk("t4_count_full", {29'b0, o_count}, 32'h4);
        ready = 1'b1; flush = 1'b1; flush_pc = 32'h103; stop_addr = 32'h108;
        push_exp(32'h100, 1'b0); push_exp(32'h104, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("t4_valid", {31'b0, o_valid}, 32'h0);
        chk("t4_count", {29'b0, o_count}, 32'h0);
        chk("t4_addr", addr1, 32'h100);
        wait_drain("t4_drain");

        // 5: hit pattern 1,0,0,1
        do_reset();
        ready = 1'b0;
        release_rst();
        @(posedge clk);
        #1 hit_en = 1'b0;
        chk("t5_addr_m1", addr1, 32'h4);
        @(posedge clk);
        #1 chk("t5_addr_m2", addr1, 32'h4);
        @(posedge clk);
        #1 hit_en = 1'b1;
        chk("t5_addr_m3", addr1, 32'h4);
        @(posedge clk);
        #1 hit_en = 1'b0;
        chk("t5_count", {29'b0, o_count}, 32'h2);
        chk("t5_addr", addr1, 32'h8);
        push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b0);
        ready = 1'b1;
        wait_drain("t5_drain");

        // 6: reset asserted with entries in flight clears outputs at once
        do_reset();
        ready = 1'b0;
        release_rst();
        repeat (3) @(posedge clk);
        #1 chk("t6_count_pre", {29'b0, o_count}, 32'h3);
        do_reset();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
